// File: rtl/led_seq_ctrl_pkg.sv
// led_pkg: shared divider width, 1 s tick count and sequencer state type
package led_pkg;
  localparam int DIV_W = 5;
  localparam logic [27:0] CNT_1S = 28'h5F5E100;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/led_seq_ctrl_if.sv
// led_seq_ctrl_if: pattern table write handshake
interface led_seq_ctrl_if #(parameter int NUM_LED = 4, parameter int NUM_STEPS = 8);
  logic                         cfg_valid_i;
  logic                         cfg_ready_o;
  logic [$clog2(NUM_STEPS)-1:0] cfg_addr_i;
  logic [NUM_LED*5-1:0]         cfg_data_i;
  modport master (output cfg_valid_i, cfg_addr_i, cfg_data_i, input cfg_ready_o);
  modport slave (input cfg_valid_i, cfg_addr_i, cfg_data_i, output cfg_ready_o);
endinterface

// File: rtl/led_seq_tick.sv
// led_seq_tick: step timer, one-cycle tick every STEP_TICKS enabled cycles
module led_seq_tick #(parameter int STEP_TICKS = 100_000_000) (
  input  logic clk100,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(STEP_TICKS);
  localparam logic [W-1:0] LAST = W'(STEP_TICKS - 1);
  logic [W-1:0] cnt;
  assign tick = en && cnt == LAST;
  always_ff @(posedge clk100)
    cnt <= (rst || clr || tick) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: steps through a flop pattern table driving per-LED dividers
module led_seq_ctrl import led_pkg::*; #(
  parameter int NUM_LED    = 4,
  parameter int NUM_STEPS  = 8,
  parameter int STEP_TICKS = int'(CNT_1S)
) (
  input  logic                           clk100,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic                           stop_i,
  input  logic [$clog2(NUM_STEPS)-1:0]   seq_len_i,
  led_seq_ctrl_if.slave                  cfg,
  output logic [NUM_LED*DIV_W-1:0]       div_o,
  output logic [NUM_LED-1:0]             wren_o,
  output logic [$clog2(NUM_STEPS)-1:0]   step_o,
  output logic                           busy_o
);
  localparam int SW = $clog2(NUM_STEPS);
  localparam int DW = NUM_LED * DIV_W;
  state_t state, state_n;
  logic [DW-1:0] tbl [NUM_STEPS];
  logic [SW-1:0] seq_len, nxt;
  logic [NUM_LED-1:0] chg;
  logic go, adv, tick;
  assign cfg.cfg_ready_o = state == IDLE && !rst;
  assign busy_o = state == RUN;
  assign go = state == IDLE && start_i && !stop_i;
  // stop beats a coincident step boundary
  assign adv = state == RUN && !stop_i && tick;
  assign nxt = step_o == seq_len ? '0 : step_o + 1'b1;
  led_seq_tick #(.STEP_TICKS(STEP_TICKS)) u_tick (
    .clk100(clk100),
    .rst(rst),
    .clr(state != RUN || stop_i),
    .en(state == RUN),
    .tick(tick)
  );
  always_ff @(posedge clk100) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = go ? RUN : (state == RUN && stop_i) ? IDLE : state;
  end
  always_comb begin
    chg = '0;
    for (int n = 0; n < NUM_LED; n++)
      chg[n] = tbl[nxt][n*DIV_W +: DIV_W] != div_o[n*DIV_W +: DIV_W];
  end
  always_ff @(posedge clk100) begin
    if (rst) begin
      for (int i = 0; i < NUM_STEPS; i++) tbl[i] <= '0;
      seq_len <= '0;
      step_o  <= '0;
      div_o   <= '0;
      wren_o  <= '0;
    end else begin
      if (cfg.cfg_valid_i && cfg.cfg_ready_o) tbl[cfg.cfg_addr_i] <= cfg.cfg_data_i;
      wren_o <= go ? '1 : adv ? chg : '0;
      if (go) begin
        seq_len <= seq_len_i;
        step_o  <= '0;
        div_o   <= tbl[0];
      end else if (adv) begin
        step_o <= nxt;
        div_o  <= tbl[nxt];
      end
    end
  end
endmodule
